// File: rtl/mmu_seq_if.sv
// mmu_seq_if: bundles every signal of the mmu_seq sequencer except the clock and reset.
//
// Signal groups:
//   job control : start, num_vec (in), busy, done (out)
//   weight beat : wt_in_valid, wt_in (in), wt_in_ready (out)
//   input vector: dat_in_valid, dat_in (in), dat_in_ready (out)
//   array side  : mmu_control, mmu_data_arr, mmu_wt_arr (out), mmu_acc_out (in)
//   result      : res_ready (in), res_valid, res_data (out)
//
// Modports:
//   slave  - the sequencer itself
//   master - the surroundings (buffers, array, result consumer)
interface mmu_seq_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 32
);
    logic                      start;
    logic [15:0]               num_vec;
    logic                      busy;
    logic                      done;

    logic                      wt_in_valid;
    logic                      wt_in_ready;
    logic [BIT_WIDTH*ROWS-1:0] wt_in;

    logic                      dat_in_valid;
    logic                      dat_in_ready;
    logic [BIT_WIDTH*COLS-1:0] dat_in;

    logic                      mmu_control;
    logic [BIT_WIDTH*COLS-1:0] mmu_data_arr;
    logic [BIT_WIDTH*ROWS-1:0] mmu_wt_arr;
    logic [ACC_WIDTH*ROWS-1:0] mmu_acc_out;

    logic                      res_valid;
    logic                      res_ready;
    logic [ACC_WIDTH*ROWS-1:0] res_data;

    modport slave (
        input  start, num_vec, wt_in_valid, wt_in, dat_in_valid, dat_in,
               mmu_acc_out, res_ready,
        output busy, done, wt_in_ready, dat_in_ready, mmu_control,
               mmu_data_arr, mmu_wt_arr, res_valid, res_data
    );

    modport master (
        output start, num_vec, wt_in_valid, wt_in, dat_in_valid, dat_in,
               mmu_acc_out, res_ready,
        input  busy, done, wt_in_ready, dat_in_ready, mmu_control,
               mmu_data_arr, mmu_wt_arr, res_valid, res_data
    );
endinterface

// File: rtl/mmu_seq.sv
// mmu_seq: job sequencer for a ROWS x COLS weight-stationary systolic MAC array.
//
// Per job: shifts one weight tile into the array (COLS beats, last column first),
// waits one settle cycle, streams num_vec input vectors with per-column skew,
// deskews the per-row sums coming back and queues them in a first-word-fall-through
// result FIFO. Input acceptance is credit limited so the FIFO can never overflow.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset (clears FSM, counters, pipelines, FIFO)
//   bus   - mmu_seq_if.slave: job control, weight/data streams, array side, results
module mmu_seq #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int ARR_LAT   = 5,
    parameter int RES_DEPTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    mmu_seq_if.slave bus
);

    // Acceptance to FIFO write: skew register + array + deskew of row 0.
    localparam int LAT    = 1 + ARR_LAT + (ROWS - 1);
    localparam int AW     = $clog2(RES_DEPTH);
    localparam int CNT_W  = $clog2(RES_DEPTH + LAT + 1);
    localparam int BEAT_W = $clog2(COLS + 1);
    localparam int DW     = BIT_WIDTH * COLS;
    localparam int RW     = ACC_WIDTH * ROWS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SETTLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        remaining;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               wt_acc;
    logic               dat_rdy;
    logic               dat_acc;

    logic [DW-1:0]      skew_p [COLS];
    logic [DW-1:0]      data_arr;
    logic [LAT-1:0]     vld_p;
    logic [RW-1:0]      dsk_p  [ROWS-1];
    logic [RW-1:0]      aligned;

    logic [RW-1:0]      mem [RES_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   inflight;
    logic               push;
    logic               pop;
    logic               full;
    logic               res_vld;

    function automatic logic [CNT_W-1:0] popcount(input logic [LAT-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Control: state register and job counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                remaining <= bus.num_vec;
            end else if (dat_acc) begin
                remaining <= remaining - 16'd1;
            end
            if (state == IDLE) begin
                beat_cnt <= '0;
            end else if (wt_acc) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wt_acc    = 1'b0;
        dat_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                wt_acc = bus.wt_in_valid;
                if (wt_acc && beat_cnt == BEAT_W'(COLS - 1)) state_nxt = SETTLE;
            end
            SETTLE: begin
                state_nxt = (remaining == 16'd0) ? DRAIN : STREAM;
            end
            STREAM: begin
                // Credit: every in-flight vector already owns a FIFO slot.
                dat_rdy = (remaining != 16'd0) &&
                          ((fifo_count + inflight) < CNT_W'(RES_DEPTH));
                if (dat_rdy && bus.dat_in_valid && remaining == 16'd1) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign dat_acc          = dat_rdy && bus.dat_in_valid;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.wt_in_ready  = (state == LOAD_W);
    assign bus.dat_in_ready = dat_rdy;
    // Weights reach the array only on the accepted beat itself.
    assign bus.mmu_control  = wt_acc;
    assign bus.mmu_wt_arr   = wt_acc ? bus.wt_in : '0;

    // Stage p0: accepted vector (or a zero bubble) and its tag enter the pipes.
    // Column c is tapped from stage c, giving the diagonal input skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < COLS; k++) skew_p[k] <= '0;
            vld_p <= '0;
        end else begin
            skew_p[0] <= dat_acc ? bus.dat_in : '0;
            for (int k = 1; k < COLS; k++) skew_p[k] <= skew_p[k-1];
            vld_p <= {vld_p[LAT-2:0], dat_acc};
        end
    end

    always_comb begin
        data_arr = '0;
        for (int c = 0; c < COLS; c++) begin
            data_arr[c*BIT_WIDTH +: BIT_WIDTH] = skew_p[c][c*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    assign bus.mmu_data_arr = data_arr;
    assign inflight         = popcount(vld_p);

    // Deskew: row r leaves the array r cycles after row 0, so it is held
    // ROWS-1-r cycles; stage dsk_p[j] adds j+1 cycles of delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < ROWS - 1; j++) dsk_p[j] <= '0;
        end else begin
            dsk_p[0] <= bus.mmu_acc_out;
            for (int j = 1; j < ROWS - 1; j++) dsk_p[j] <= dsk_p[j-1];
        end
    end

    always_comb begin
        aligned = '0;
        for (int r = 0; r < ROWS - 1; r++) begin
            aligned[r*ACC_WIDTH +: ACC_WIDTH] = dsk_p[ROWS-2-r][r*ACC_WIDTH +: ACC_WIDTH];
        end
        aligned[(ROWS-1)*ACC_WIDTH +: ACC_WIDTH] =
            bus.mmu_acc_out[(ROWS-1)*ACC_WIDTH +: ACC_WIDTH];
    end

    // Result FIFO: write when the tag of a real vector reaches the end of the pipe.
    assign push    = vld_p[LAT-1];
    assign res_vld = (fifo_count != '0);
    assign pop     = res_vld && bus.res_ready;
    assign full    = (fifo_count == CNT_W'(RES_DEPTH));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= aligned;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    assign bus.res_valid = res_vld;
    assign bus.res_data  = res_vld ? mem[rd_ptr] : '0;

    // A push into a full FIFO without a matching pop would lose a result.
    assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: doc/mmu_seq.md
Name: mmu_seq

Overview:
- Sequencer for the 4x4 weight-stationary systolic MAC array (mmu).
- Per job it loads one weight tile through the array's horizontal weight path.
- It then streams N input vectors with per-column input skew, deskews the per-row accumulator outputs, and buffers results in a credit-protected result FIFO with a valid/ready output.
- It sits between the weight/activation buffers and the array instance, and owns the array's control input.

Parameters:
- ROWS, 4, array rows (result lanes).
- COLS, 4, array columns (input lanes).
- BIT_WIDTH, 8, data/weight element width.
- ACC_WIDTH, 32, accumulator width.
- ARR_LAT, 5, cycles from an unskewed column-0 element at mmu_data_arr to the row-0 sum at mmu_acc_out.
- RES_DEPTH, 16, result FIFO entries (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job start pulse, sampled in IDLE only.
- num_vec  in  16  vectors in the job, sampled with start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- wt_in_valid  in  1  weight beat valid.
- wt_in_ready  out  1  weight beat accepted when valid&ready.
- wt_in  in  BIT_WIDTH*ROWS  one weight column; lane r = row r.
- dat_in_valid  in  1  input vector valid.
- dat_in_ready  out  1  input vector accepted when valid&ready.
- dat_in  in  BIT_WIDTH*COLS  input vector; lane c = column c.
- mmu_control  out  1  array control: 1 = weight shift, 0 = compute.
- mmu_data_arr  out  BIT_WIDTH*COLS  skewed data to the array top.
- mmu_wt_arr  out  BIT_WIDTH*ROWS  weights to the array left edge.
- mmu_acc_out  in  ACC_WIDTH*ROWS  array row sums.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  result consumer ready.
- res_data  out  ACC_WIDTH*ROWS  deskewed result; lane r = row r.

Behaviour:
- Reset values: busy=0, done=0, wt_in_ready=0, dat_in_ready=0, mmu_control=0, mmu_data_arr=0, mmu_wt_arr=0, res_valid=0, res_data=0.
- Reset also clears the FSM to IDLE, all counters, the skew/deskew/tag pipelines and the FIFO. Reset mid-job abandons the job with no done pulse.
- FSM states: IDLE, LOAD_W, SETTLE, STREAM, DRAIN, DONE.
- IDLE:
  - On start, latch num_vec and go to LOAD_W.
  - start outside IDLE is ignored.
- LOAD_W:
  - wt_in_ready=1.
  - Each accepted beat drives mmu_wt_arr=wt_in with mmu_control=1 for exactly that cycle; otherwise mmu_control=0 and mmu_wt_arr=0.
  - Beat k (0..COLS-1) carries weight column COLS-1-k, so after COLS beats column c holds W[.][c].
  - After COLS beats, go to SETTLE.
- SETTLE:
  - One cycle with mmu_control=0 and zero data.
  - Then go to STREAM, or to DRAIN if num_vec==0.
- STREAM:
  - dat_in_ready = (remaining>0) && (fifo_count + inflight < RES_DEPTH).
  - An accepted vector enters the skew pipe; column c reaches mmu_data_arr c cycles after column 0.
  - Cycles without acceptance inject zero (bubble), with tag=0.
  - When remaining hits 0, go to DRAIN.
- Tag pipe:
  - A 1-bit shift register follows each vector; it is 1 for an accepted vector.
  - inflight = popcount of the tag pipe.
  - Total latency LAT = 1 + ARR_LAT + (ROWS-1). A vector accepted at cycle T has its result written to the FIFO at T+LAT if its tag is 1.
- Deskew: row r of mmu_acc_out is delayed ROWS-1-r cycles so all rows align.
- DRAIN: wait until inflight==0, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. FIFO contents persist across jobs.
- FIFO:
  - First-word fall-through; res_data is valid when res_valid=1.
  - Simultaneous push and pop on the same cycle is allowed, including when full or when empty-with-push.
  - The credit rule guarantees no overflow; a push while full is an assertion failure.
- Arithmetic: no arithmetic in this block; sums pass through unmodified at ACC_WIDTH.
- The array's weights persist until the next LOAD_W.

Test Plan:
- Identity weights (W[r][c]=1 if r==c), num_vec=3, vectors {1,2,3,4},{5,6,7,8},{-1,0,0,2}, res_ready=1 -> three results {1,2,3,4},{5,6,7,8},{-1,0,0,2} in order, first at LAT cycles after acceptance; done pulses once; busy drops the next cycle.
- All-2 weights, vector {1,1,1,1} -> every lane 8; weight beats gated by wt_in_valid toggling -> mmu_control high only on accepted beats, 4 pulses total.
- res_ready=0, num_vec=20 -> dat_in_ready drops after exactly 16 accepted vectors; no FIFO overflow. Raise res_ready -> remaining 4 vectors accepted; 20 results total, in order.
- num_vec=0 -> LOAD_W, SETTLE, DRAIN, DONE; done pulses; no results pushed.
- Reset asserted on the 2nd STREAM vector -> all outputs at reset values the next cycle; no done pulse; FIFO empty. A new job afterwards runs normally.
- start pulsed during STREAM -> ignored; job count and results unchanged.
